// File: rtl/tmr_recovery_ctrl.sv
// tmr_recovery_ctrl: supervisory FSM for a triple-modular-redundant datapath.
//
// Filters transient voter mismatches, identifies a persistently faulty replica, halts the
// replicated pipeline and sequences a resync of that replica. No-majority or a resync
// timeout escalates to a latched fatal state that only clear_i releases.
//
// Optional feature: define TMR_CTRL_LOG_EN to add a 16-bit free-running cycle counter whose
// value is captured into log_stamp_o on every entry to HALT or FATAL. Without it,
// log_stamp_o is tied to 0; the port list is the same in both builds.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   valid_i       voter comparison result valid this cycle
//   mismatch_i    bit k set: replica k disagrees with the voted value
//   detected_i    voter found no majority
//   resync_ack_i  resync of resync_id_o complete (pulse)
//   clear_i       clear FATAL and all counters
//   halt_o        stall the replicated pipeline
//   resync_req_o  request state copy into replica resync_id_o
//   resync_id_o   faulty replica index (valid while resync_req_o is high)
//   fatal_o       unrecoverable fault, latched
//   err_cnt*_o    saturating count of recoveries per replica
//   log_stamp_o   cycle stamp of the last HALT/FATAL entry
module tmr_recovery_ctrl #(
  parameter int unsigned SUSPECT_THRESH = 2,
  parameter int unsigned ACK_TIMEOUT    = 8,
  parameter int unsigned ERR_CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [2:0]           mismatch_i,
  input  logic                 detected_i,
  input  logic                 resync_ack_i,
  input  logic                 clear_i,
  output logic                 halt_o,
  output logic                 resync_req_o,
  output logic [1:0]           resync_id_o,
  output logic                 fatal_o,
  output logic [ERR_CNT_W-1:0] err_cnt0_o,
  output logic [ERR_CNT_W-1:0] err_cnt1_o,
  output logic [ERR_CNT_W-1:0] err_cnt2_o,
  output logic [15:0]          log_stamp_o
);

  localparam int unsigned ConsW = $clog2(SUSPECT_THRESH + 1);
  localparam int unsigned TmrW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ConsW-1:0] ConsThr = ConsW'(SUSPECT_THRESH);
  localparam logic [TmrW-1:0]  TmrThr  = TmrW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StSuspect, StHalt, StResync, StFatal} state_e;

  state_e               state_q, state_d;
  logic [1:0]           id_q, id_d;
  logic [ConsW-1:0]     cons_q, cons_d;
  logic [TmrW-1:0]      timer_q, timer_d;
  logic [ERR_CNT_W-1:0] err_cnt_q [3];
  logic [ERR_CNT_W-1:0] err_cnt_d [3];
  logic                 halt_q, halt_d, req_q, req_d, fatal_q, fatal_d;
  logic [1:0]           rid_q, rid_d;

  logic       one_hot, single, multi;
  logic [1:0] hit_id;

  // Exactly one bit set; a non-zero vector that is not one-hot has >= 2 bits set.
  assign one_hot = (mismatch_i != 3'b000) && ((mismatch_i & (mismatch_i - 3'd1)) == 3'b000);
  assign single  = valid_i & ~detected_i & one_hot;
  assign multi   = valid_i & (detected_i | ((mismatch_i != 3'b000) & ~one_hot));

  always_comb begin
    hit_id = 2'd0;
    if (mismatch_i[1]) hit_id = 2'd1;
    if (mismatch_i[2]) hit_id = 2'd2;
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    cons_d    = cons_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (multi) begin
          state_d = StFatal;
        end else if (single) begin
          id_d = hit_id;
          if (ConsThr == ConsW'(1)) begin
            state_d = StHalt;
            cons_d  = '0;
          end else begin
            state_d = StSuspect;
            cons_d  = ConsW'(1);
          end
        end
      end
      StSuspect: begin
        if (multi) begin
          state_d = StFatal;
          cons_d  = '0;
        end else if (single) begin
          if (hit_id == id_q) begin
            if (cons_q + ConsW'(1) == ConsThr) begin
              state_d = StHalt;
              cons_d  = '0;
            end else begin
              cons_d = cons_q + ConsW'(1);
            end
          end else begin
            id_d   = hit_id;
            cons_d = ConsW'(1);
          end
        end else if (valid_i) begin
          // Valid and not single/multi means a clean comparison.
          state_d = StIdle;
          cons_d  = '0;
        end
      end
      StHalt: begin
        for (int k = 0; k < 3; k++) begin
          if (id_q == 2'(k) && err_cnt_q[k] != '1) err_cnt_d[k] = err_cnt_q[k] + 1'b1;
        end
        state_d = StResync;
        timer_d = '0;
      end
      StResync: begin
        // Ack takes priority over a simultaneous timer expiry.
        if (resync_ack_i) begin
          state_d = StIdle;
        end else if (timer_q + TmrW'(1) == TmrThr) begin
          state_d = StFatal;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StFatal: begin
        if (clear_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clear overrides any increment computed above.
    if (clear_i) begin
      cons_d = '0;
      for (int k = 0; k < 3; k++) err_cnt_d[k] = '0;
    end
  end

  // Outputs are registered images of the next state.
  always_comb begin
    halt_d  = (state_d == StHalt) || (state_d == StResync) || (state_d == StFatal);
    req_d   = (state_d == StResync);
    rid_d   = (state_d == StResync) ? id_d : 2'd0;
    fatal_d = (state_d == StFatal);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= 2'd0;
      cons_q  <= '0;
      timer_q <= '0;
      for (int k = 0; k < 3; k++) err_cnt_q[k] <= '0;
      halt_q  <= 1'b0;
      req_q   <= 1'b0;
      rid_q   <= 2'd0;
      fatal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      cons_q    <= cons_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      halt_q    <= halt_d;
      req_q     <= req_d;
      rid_q     <= rid_d;
      fatal_q   <= fatal_d;
    end
  end

  assign halt_o       = halt_q;
  assign resync_req_o = req_q;
  assign resync_id_o  = rid_q;
  assign fatal_o      = fatal_q;
  assign err_cnt0_o   = err_cnt_q[0];
  assign err_cnt1_o   = err_cnt_q[1];
  assign err_cnt2_o   = err_cnt_q[2];

`ifdef TMR_CTRL_LOG_EN
  logic [15:0] cyc_q, cyc_d, stamp_q, stamp_d;

  always_comb begin
    cyc_d   = cyc_q + 16'd1;
    stamp_d = stamp_q;
    if ((state_d == StHalt && state_q != StHalt) || (state_d == StFatal && state_q != StFatal)) begin
      stamp_d = cyc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= 16'd0;
      stamp_q <= 16'd0;
    end else begin
      cyc_q   <= cyc_d;
      stamp_q <= stamp_d;
    end
  end

  assign log_stamp_o = stamp_q;
`else
  assign log_stamp_o = 16'd0;
`endif

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl with SUSPECT_THRESH=2, ACK_TIMEOUT=8, ERR_CNT_W=2.
module tb_tmr_recovery_ctrl;

`ifdef TMR_CTRL_LOG_EN
  localparam bit LogEn = 1'b1;
`else
  localparam bit LogEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, valid_i, detected_i, resync_ack_i, clear_i;
  logic [2:0] mismatch_i;
  logic       halt_o, resync_req_o, fatal_o;
  logic [1:0] resync_id_o, err_cnt0_o, err_cnt1_o, err_cnt2_o;
  logic [15:0] log_stamp_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] tb_cyc;
  logic [15:0] exp_stamp;

  tmr_recovery_ctrl #(
    .SUSPECT_THRESH (2),
    .ACK_TIMEOUT    (8),
    .ERR_CNT_W      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .mismatch_i   (mismatch_i),
    .detected_i   (detected_i),
    .resync_ack_i (resync_ack_i),
    .clear_i      (clear_i),
    .halt_o       (halt_o),
    .resync_req_o (resync_req_o),
    .resync_id_o  (resync_id_o),
    .fatal_o      (fatal_o),
    .err_cnt0_o   (err_cnt0_o),
    .err_cnt1_o   (err_cnt1_o),
    .err_cnt2_o   (err_cnt2_o),
    .log_stamp_o  (log_stamp_o)
  );

  always #5 clk = ~clk;

  // Independent cycle reference for the log stamp.
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= 16'd0;
    else        tb_cyc <= tb_cyc + 16'd1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {halt, req, id[1:0], fatal}
  function automatic logic [15:0] ctl();
    return {11'd0, halt_o, resync_req_o, resync_id_o, fatal_o};
  endfunction

  function automatic logic [15:0] errs();
    return {10'd0, err_cnt2_o, err_cnt1_o, err_cnt0_o};
  endfunction

  // Two consecutive single mismatches on replica r; returns after the HALT entry edge.
  task automatic to_halt(input logic [2:0] mm);
    valid_i = 1'b1; mismatch_i = mm;
    cyc(2);
    valid_i = 1'b0; mismatch_i = 3'b000;
  endtask

  task automatic recover(input logic [2:0] mm, output logic [15:0] halt_stamp);
    to_halt(mm);
    halt_stamp = LogEn ? tb_cyc - 16'd1 : 16'd0;
    cyc(1);
    resync_ack_i = 1'b1;
    cyc(1);
    resync_ack_i = 1'b0;
  endtask

  initial begin
    logic [15:0] st;
    rst_n = 1'b0; valid_i = 1'b0; mismatch_i = 3'b000; detected_i = 1'b0;
    resync_ack_i = 1'b0; clear_i = 1'b0;
    cyc(2);
    chk("reset_ctl", ctl(), 16'h0000);
    chk("reset_err", errs(), 16'h0000);
    chk("reset_log", log_stamp_o, 16'h0000);
    rst_n = 1'b1;

    // Transient on replica 1 filtered out.
    valid_i = 1'b1; mismatch_i = 3'b010;
    cyc(1);
    chk("transient_suspect", ctl(), 16'h0000);
    mismatch_i = 3'b000;
    cyc(1);
    valid_i = 1'b0;
    chk("transient_ctl", ctl(), 16'h0000);
    chk("transient_err", errs(), 16'h0000);

    // Recovery of replica 1: halt, then request with id 1, ack after 3 RESYNC cycles.
    to_halt(3'b010);
    chk("rec1_halt", ctl(), 16'b10000);
    cyc(1);
    chk("rec1_resync", ctl(), 16'b11010);
    chk("rec1_err_inc", errs(), 16'b000100);
    cyc(2);
    chk("rec1_still_resync", ctl(), 16'b11010);
    resync_ack_i = 1'b1;
    cyc(1);
    resync_ack_i = 1'b0;
    chk("rec1_done", ctl(), 16'h0000);
    chk("rec1_err", errs(), 16'b000100);

    // Stray ack in IDLE does nothing.
    resync_ack_i = 1'b1;
    cyc(1);
    resync_ack_i = 1'b0;
    chk("stray_ack", ctl(), 16'h0000);

    // Timeout on replica 2.
    to_halt(3'b100);
    cyc(1);
    chk("to_resync", ctl(), 16'b11100);
    chk("to_err", errs(), 16'b010100);
    cyc(7);
    chk("to_before_expiry", ctl(), 16'b11100);
    cyc(1);
    chk("to_fatal", ctl(), 16'b10001);
    chk("to_log", log_stamp_o, LogEn ? tb_cyc - 16'd1 : 16'd0);
    valid_i = 1'b1; mismatch_i = 3'b010;
    cyc(2);
    valid_i = 1'b0; mismatch_i = 3'b000;
    chk("fatal_ignores_input", ctl(), 16'b10001);
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    chk("clear_ctl", ctl(), 16'h0000);
    chk("clear_err", errs(), 16'h0000);

    // No majority: detected flag, then two mismatch bits.
    valid_i = 1'b1; detected_i = 1'b1;
    cyc(1);
    valid_i = 1'b0; detected_i = 1'b0;
    chk("nomaj_detected", ctl(), 16'b10001);
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;
    chk("nomaj_clear", ctl(), 16'h0000);
    valid_i = 1'b1; mismatch_i = 3'b011;
    cyc(1);
    valid_i = 1'b0; mismatch_i = 3'b000;
    chk("nomaj_two_bits", ctl(), 16'b10001);
    clear_i = 1'b1;
    cyc(1);
    clear_i = 1'b0;

    // Ack on the expiry cycle wins over the timeout.
    to_halt(3'b001);
    cyc(8);
    chk("race_pre", ctl(), 16'b11000);
    resync_ack_i = 1'b1;
    cyc(1);
    resync_ack_i = 1'b0;
    chk("race_ack_wins", ctl(), 16'h0000);
    chk("race_err", errs(), 16'b000001);

    // Reset in the middle of RESYNC.
    to_halt(3'b010);
    cyc(1);
    chk("rst_mid_pre", ctl(), 16'b11010);
    rst_n = 1'b0;
    cyc(1);
    chk("rst_mid_ctl", ctl(), 16'h0000);
    chk("rst_mid_err", errs(), 16'h0000);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_mid_no_pending", ctl(), 16'h0000);

    // Saturation of replica 0 counter after four recoveries.
    recover(3'b001, st);
    recover(3'b001, st);
    chk("sat_two", errs(), 16'b000010);
    recover(3'b001, st);
    recover(3'b001, st);
    chk("sat_four", errs(), 16'b000011);
    chk("sat_log", log_stamp_o, st);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
